yrv_alchrity_top: RTL and testbench

//  Board-level top for the YRV RV32 MCU on the Alchitry FPGA board plus IO board.

---
 rtl/yrv_alchrity_if.sv | 42 ++++
 rtl/yrv_alchrity_top.sv | 233 +++++++++++++++++++++++
 tb/tb_yrv_alchrity_top.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/yrv_alchrity_if.sv
// rtl/yrv_alchrity_if.sv - Alchitry board and IO-board pin bundle for the YRV MCU top
//
// Purpose: groups every board pin other than the clock and reset so the top
// level and its environment share one definition.
//   master : the board side (drives buttons/switches/serial-in, observes LEDs,
//            segments and debug headers)
//   slave  : yrv_alchrity_top (samples inputs, drives outputs)
// Pin summary:
//   NMI_brd (active-low), C6/C8/C9_brd, DI_brd, S_io[5:1], DIP_io[24:1]  -> top
//   DO_brd, SCK_brd, LED_brd[7:0], L_io[24:1], RA..RG_io, RDP_io,
//   AN_io[4:1], C42/C43/C45/C46_brd                                      <- top
interface yrv_alchrity_if;
  logic        NMI_brd;
  logic        C6_brd;
  logic        C8_brd;
  logic        C9_brd;
  logic        DI_brd;
  logic [5:1]  S_io;
  logic [24:1] DIP_io;

  logic        DO_brd;
  logic        SCK_brd;
  logic [7:0]  LED_brd;
  logic [24:1] L_io;
  logic        RA_io, RB_io, RC_io, RD_io, RE_io, RF_io, RG_io, RDP_io;
  logic [4:1]  AN_io;
  logic        C42_brd, C43_brd, C45_brd, C46_brd;

  modport master (
    output NMI_brd, C6_brd, C8_brd, C9_brd, DI_brd, S_io, DIP_io,
    input  DO_brd, SCK_brd, LED_brd, L_io,
    input  RA_io, RB_io, RC_io, RD_io, RE_io, RF_io, RG_io, RDP_io, AN_io,
    input  C42_brd, C43_brd, C45_brd, C46_brd
  );

  modport slave (
    input  NMI_brd, C6_brd, C8_brd, C9_brd, DI_brd, S_io, DIP_io,
    output DO_brd, SCK_brd, LED_brd, L_io,
    output RA_io, RB_io, RC_io, RD_io, RE_io, RF_io, RG_io, RDP_io, AN_io,
    output C42_brd, C43_brd, C45_brd, C46_brd
  );
endinterface

// File: rtl/yrv_alchrity_top.sv
// rtl/yrv_alchrity_top.sv - Alchitry board top wrapping yrv_mcu: sync, NMI edge, heartbeat, 7-seg
//
// Purpose: sole logic between the board pins and yrv_mcu. Synchronises reset
// release and all button/switch inputs, turns the NMI button into a one-cycle
// request, maps MCU ports to pins, runs the heartbeat and drives the display.
// Ports:
//   MHZ_100   in  100 MHz clock, every flop is posedge of it
//   RESET_brd in  board reset, active-low, asserts asynchronously
//   pins      yrv_alchrity_if.slave, all remaining board pins
// Macros:
//   SEG_SCAN_EN       defined: multiplexed hex display of port0_reg[15:0]
//                     undefined: segments/anodes driven directly from port0_reg
//   YRV_MCU_EXTERNAL  defined: the real yrv_mcu is supplied by the core sources
//                     undefined: the loopback stand-in below is built instead

`ifndef YRV_MCU_EXTERNAL
// Loopback stand-in with the yrv_mcu port list so the board top elaborates
// without the core: ports 0/1 echo port4_in, port 2 echoes port5_in,
// port 3 shows the interrupt lines, ser_txd echoes ser_rxd one cycle late.
module yrv_mcu (
  input  logic        clk,
  input  logic        resetb,
  input  logic        ei_req,
  input  logic        nmi_req,
  input  logic        ser_rxd,
  input  logic [15:0] port4_in,
  input  logic [15:0] port5_in,
  output logic [15:0] port0_reg,
  output logic [15:0] port1_reg,
  output logic [15:0] port2_reg,
  output logic [15:0] port3_reg,
  output logic        ser_clk,
  output logic        ser_txd,
  output logic        wfi_state,
  output logic        debug_mode
);
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      port0_reg <= '0;
      port1_reg <= '0;
      port2_reg <= '0;
      port3_reg <= '0;
      ser_txd   <= 1'b1;
    end else begin
      port0_reg <= port4_in;
      port1_reg <= port4_in;
      port2_reg <= port5_in;
      port3_reg <= {12'h000, ei_req, nmi_req, 2'b00};
      ser_txd   <= ser_rxd;
    end
  end

  assign ser_clk    = 1'b0;
  assign wfi_state  = 1'b0;
  assign debug_mode = 1'b0;
endmodule
`endif

module yrv_alchrity_top #(
  parameter int SYNC_STAGES = 2,
  parameter int HB_DIV      = 4,
  parameter int HB_BITS     = 7,
  parameter int SCAN_BITS   = 14
) (
  input logic           MHZ_100,
  input logic           RESET_brd,
  yrv_alchrity_if.slave pins
);
  localparam int IN_W  = 33;
  localparam int PRE_W = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;

  // Reset: asynchronous assert, release walks through SYNC_STAGES flops.
  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic                   rst_n;

  always_ff @(posedge MHZ_100 or negedge RESET_brd) begin
    if (!RESET_brd) rst_sync_q <= '0;
    else            rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
  end
  assign rst_n = rst_sync_q[SYNC_STAGES-1];

  // Input synchronisers. Everything resets to 0; for the active-low NMI button
  // that means "pressed", so a press held through reset never yields an edge.
  logic [IN_W-1:0]                  in_raw, in_s;
  logic [SYNC_STAGES-1:0][IN_W-1:0] in_sync_q;

  assign in_raw = {pins.NMI_brd, pins.C6_brd, pins.C8_brd, pins.C9_brd, pins.S_io, pins.DIP_io};

  always_ff @(posedge MHZ_100 or negedge rst_n) begin
    if (!rst_n) in_sync_q <= '0;
    else        in_sync_q <= {in_sync_q[SYNC_STAGES-2:0], in_raw};
  end
  assign in_s = in_sync_q[SYNC_STAGES-1];

  logic        nmi_n_s, c6_s, c8_s, c9_s;
  logic [4:0]  s_s;
  logic [23:0] dip_s;
  assign {nmi_n_s, c6_s, c8_s, c9_s, s_s, dip_s} = in_s;

  // NMI: registered falling-edge detect. nmi_hi_q starts low, so the button
  // must be seen released after reset before a press can count.
  logic nmi_hi_q, nmi_req_q;

  always_ff @(posedge MHZ_100 or negedge rst_n) begin
    if (!rst_n) begin
      nmi_hi_q  <= 1'b0;
      nmi_req_q <= 1'b0;
    end else begin
      nmi_hi_q  <= nmi_n_s;
      nmi_req_q <= nmi_hi_q & ~nmi_n_s;
    end
  end

  // MCU
  logic        ei_req, nmi_req;
  logic [15:0] port4_in, port5_in;
  logic [15:0] port0_reg, port1_reg, port2_reg, port3_reg;
  logic        ser_clk, ser_txd, wfi_state, debug_mode;

  assign ei_req   = c6_s;
  assign nmi_req  = nmi_req_q;
  assign port4_in = dip_s[15:0];
  assign port5_in = {dip_s[23:16], c9_s, c8_s, 1'b0, s_s};

  yrv_mcu u_mcu (
    .clk        (MHZ_100),
    .resetb     (rst_n),
    .ei_req     (ei_req),
    .nmi_req    (nmi_req),
    .ser_rxd    (pins.DI_brd),
    .port4_in   (port4_in),
    .port5_in   (port5_in),
    .port0_reg  (port0_reg),
    .port1_reg  (port1_reg),
    .port2_reg  (port2_reg),
    .port3_reg  (port3_reg),
    .ser_clk    (ser_clk),
    .ser_txd    (ser_txd),
    .wfi_state  (wfi_state),
    .debug_mode (debug_mode)
  );

  // Heartbeat: prescaler 0..HB_DIV-1, counter advances on each wrap.
  logic [PRE_W-1:0]   hb_pre_q, hb_pre_d;
  logic [HB_BITS-1:0] hb_cnt_q, hb_cnt_d;

  always_comb begin
    hb_pre_d = hb_pre_q + 1'b1;
    hb_cnt_d = hb_cnt_q;
    if (hb_pre_q == PRE_W'(HB_DIV - 1)) begin
      hb_pre_d = '0;
      hb_cnt_d = hb_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge MHZ_100 or negedge rst_n) begin
    if (!rst_n) begin
      hb_pre_q <= '0;
      hb_cnt_q <= '0;
    end else begin
      hb_pre_q <= hb_pre_d;
      hb_cnt_q <= hb_cnt_d;
    end
  end

  // Display, computed active-high then inverted at the pins.
  logic [6:0] seg_on;   // {g,f,e,d,c,b,a}
  logic       dp_on;
  logic [3:0] an_on;
  logic       unused_ok;

`ifdef SEG_SCAN_EN
  logic [SCAN_BITS-1:0] scan_q, scan_d;
  logic [1:0]           digit;
  logic [3:0]           nib;

  assign scan_d = scan_q + 1'b1;

  always_ff @(posedge MHZ_100 or negedge rst_n) begin
    if (!rst_n) scan_q <= '0;
    else        scan_q <= scan_d;
  end

  assign digit = scan_q[SCAN_BITS-1 -: 2];
  assign nib   = port0_reg[{digit, 2'b00} +: 4];
  assign dp_on = port3_reg[digit];
  assign an_on = 4'b0001 << digit;

  always_comb begin
    seg_on = 7'h00;
    case (nib)
      4'h0: seg_on = 7'h3F;
      4'h1: seg_on = 7'h06;
      4'h2: seg_on = 7'h5B;
      4'h3: seg_on = 7'h4F;
      4'h4: seg_on = 7'h66;
      4'h5: seg_on = 7'h6D;
      4'h6: seg_on = 7'h7D;
      4'h7: seg_on = 7'h07;
      4'h8: seg_on = 7'h7F;
      4'h9: seg_on = 7'h6F;
      4'hA: seg_on = 7'h77;
      4'hB: seg_on = 7'h7C;
      4'hC: seg_on = 7'h39;
      4'hD: seg_on = 7'h5E;
      4'hE: seg_on = 7'h79;
      4'hF: seg_on = 7'h71;
      default: seg_on = 7'h00;
    endcase
  end

  assign unused_ok = ^port3_reg[15:4];
`else
  assign seg_on    = port0_reg[6:0];
  assign dp_on     = port0_reg[7];
  assign an_on     = port0_reg[11:8];
  assign unused_ok = ^{port3_reg, port0_reg[15:12]};
`endif

  // Pin mapping. Segment/anode gating on rst_n blanks the display the moment
  // reset asserts, independent of what port0_reg held.
  assign pins.DO_brd  = ser_txd;
  assign pins.SCK_brd = ser_clk;
  assign pins.LED_brd = port2_reg[7:0];
  assign pins.L_io    = {port2_reg[15:8], port1_reg};
  assign {pins.RDP_io, pins.RG_io, pins.RF_io, pins.RE_io,
          pins.RD_io, pins.RC_io, pins.RB_io, pins.RA_io} = rst_n ? ~{dp_on, seg_on} : 8'hFF;
  assign pins.AN_io   = rst_n ? ~an_on : 4'hF;
  assign pins.C42_brd = ~rst_n;
  assign pins.C43_brd = wfi_state;
  assign pins.C45_brd = debug_mode;
  assign pins.C46_brd = hb_cnt_q[HB_BITS-1];
endmodule

// File: tb/tb_yrv_alchrity_top.sv
// tb/tb_yrv_alchrity_top.sv - directed/randomised self-checking bench for yrv_alchrity_top
module tb_yrv_alchrity_top;
  localparam int SYNC    = 2;
  localparam int HB_DIV  = 4;
  localparam int HB_BITS = 7;
  localparam int HB_HALF = HB_DIV * (1 << (HB_BITS - 1));

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  yrv_alchrity_if bus();

  yrv_alchrity_top dut (
    .MHZ_100   (clk),
    .RESET_brd (rst_b),
    .pins      (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] f0, f1, f2, f3;

  // Active-high {g..a} patterns for hex digits 0..F.
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] segs();
    return {bus.RDP_io, bus.RG_io, bus.RF_io, bus.RE_io,
            bus.RD_io, bus.RC_io, bus.RB_io, bus.RA_io};
  endfunction

  task automatic wait_hb(input logic lvl, input int limit, output int n);
    n = 0;
    while (bus.C46_brd !== lvl && n < limit) begin
      tick();
      n++;
    end
  endtask

  // Drive NMI low and watch for `len` cycles: number of pulse cycles and the
  // cycle index (1-based) of the first one.
  task automatic nmi_press(input int len, output int cnt, output int first);
    cnt = 0;
    first = -1;
    bus.NMI_brd = 1'b0;
    for (int i = 1; i <= len; i++) begin
      tick();
      if (dut.nmi_req === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic reset_checks(input string pfx);
    check({pfx, "_led"}, bus.LED_brd, 8'h00);
    check({pfx, "_lio"}, bus.L_io, 24'h0);
    check({pfx, "_do"}, bus.DO_brd, 1'b1);
    check({pfx, "_sck"}, bus.SCK_brd, 1'b0);
    check({pfx, "_c42"}, bus.C42_brd, 1'b1);
    check({pfx, "_c43"}, bus.C43_brd, 1'b0);
    check({pfx, "_c45"}, bus.C45_brd, 1'b0);
    check({pfx, "_c46"}, bus.C46_brd, 1'b0);
    check({pfx, "_segs"}, segs(), 8'hFF);
    check({pfx, "_an"}, bus.AN_io, 4'hF);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, first;
    logic [23:0] dip;
    logic [4:0]  s;
    logic        c6, c8, c9;
    logic [31:0] exp5;

    bus.NMI_brd = 1'b0; bus.C6_brd = 1'b0; bus.C8_brd = 1'b0; bus.C9_brd = 1'b0;
    bus.DI_brd = 1'b0; bus.S_io = '0; bus.DIP_io = '0;

    // Reset held for 3 cycles
    tick(3);
    reset_checks("rst");
    check("rst_nmi", dut.nmi_req, 1'b0);

    // Heartbeat first rise and half period
    rst_b = 1'b1;
    tick();
    wait_hb(1'b1, 1000, n);
    check_rng("hb_rise", n + 1, HB_HALF + SYNC - 1, HB_HALF + SYNC + 1);
    check("run_c42", bus.C42_brd, 1'b0);
    tick(140);
    check("hb_high_at_400", bus.C46_brd, 1'b1);

    // Mid-operation reset drops outputs at once, heartbeat restarts
    rst_b = 1'b0;
    #1;
    reset_checks("mid");
    tick(3);
    rst_b = 1'b1;
    tick();
    wait_hb(1'b1, 1000, n);
    check_rng("hb_rise2", n + 1, HB_HALF + SYNC - 1, HB_HALF + SYNC + 1);
    wait_hb(1'b0, 1000, n);
    check("hb_half_period", n, HB_HALF);

    // NMI held low 50 cycles: exactly one pulse, SYNC+1 cycles after the edge
    bus.NMI_brd = 1'b1;
    tick(5);
    check("nmi_idle", dut.nmi_req, 1'b0);
    nmi_press(50, cnt, first);
    check("nmi_pulses", cnt, 1);
    check("nmi_latency", first, SYNC + 1);

    // NMI pressed during reset and held: ignored
    bus.NMI_brd = 1'b1;
    tick(3);
    rst_b = 1'b0;
    tick(2);
    bus.NMI_brd = 1'b0;
    tick(2);
    rst_b = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dut.nmi_req === 1'b1) cnt++;
    end
    check("nmi_in_reset_ignored", cnt, 0);
    bus.NMI_brd = 1'b1;
    tick(5);
    nmi_press(10, cnt, first);
    check("nmi_after_reset_pulses", cnt, 1);
    bus.NMI_brd = 1'b1;

    // Input mapping after synchronisation: one directed case, then random
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        dip = 24'hA5_1234; s = 5'h1F; c8 = 1'b1; c9 = 1'b0; c6 = 1'b1;
      end else begin
        dip = 24'($urandom);
        s   = 5'($urandom_range(0, 31));
        c8  = 1'($urandom_range(0, 1));
        c9  = 1'($urandom_range(0, 1));
        c6  = 1'($urandom_range(0, 1));
      end
      bus.DIP_io = dip; bus.S_io = s; bus.C8_brd = c8; bus.C9_brd = c9; bus.C6_brd = c6;
      tick(SYNC);
      exp5 = ((32'(dip) >> 16) & 32'hFF) * 256 + 32'(c9) * 128 + 32'(c8) * 64 + 32'(s);
      check("port4_in", dut.port4_in, 32'(dip) % 65536);
      check("port5_in", dut.port5_in, exp5);
      check("ei_req", dut.ei_req, c6);
    end

    // LED / IO-LED mapping from forced port1/port2
    for (int i = 0; i < 5; i++) begin
      f1 = (i == 0) ? 16'h0000 : 16'($urandom);
      f2 = (i == 0) ? 16'h55AA : 16'($urandom);
      force dut.port1_reg = f1;
      force dut.port2_reg = f2;
      #1;
      check("led_brd", bus.LED_brd, 32'(f2) % 256);
      check("l_io", bus.L_io, (32'(f2) / 256) * 65536 + 32'(f1));
    end
    release dut.port1_reg;
    release dut.port2_reg;

`ifdef SEG_SCAN_EN
    // Scanned hex display: digit 0 (AN[1]) and digit 3 (AN[4])
    f0 = 16'h12AF;
    f3 = 16'h0001;
    force dut.port0_reg = f0;
    force dut.port3_reg = f3;
    n = 0;
    while (bus.AN_io !== 4'hE && n < 20000) begin tick(); n++; end
    check("scan_an_digit1", bus.AN_io, 4'hE);
    check("scan_segs_digit1", segs(), {1'b0, ~hex_tab[15]});
    n = 0;
    while (bus.AN_io !== 4'h7 && n < 20000) begin tick(); n++; end
    check("scan_an_digit4", bus.AN_io, 4'h7);
    check("scan_segs_digit4", segs(), {1'b1, ~hex_tab[1]});
    release dut.port0_reg;
    release dut.port3_reg;
`else
    // Direct segment/anode drive from port0_reg
    for (int i = 0; i < 5; i++) begin
      f0 = (i == 0) ? 16'h12AF : 16'($urandom);
      force dut.port0_reg = f0;
      #1;
      check("direct_segs", segs(), 32'hFF - (32'(f0) % 256));
      check("direct_an", bus.AN_io, 32'hF - ((32'(f0) / 256) % 16));
    end
    release dut.port0_reg;
    f3 = hex_tab[0];
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
